pc_unit: RTL and testbench

//  Program-counter stage of the single-cycle MIPS datapath; sits directly downstream of the branch AND gate.

---
 rtl/pc_unit_pkg.sv | 19 +
 rtl/pc_unit_if.sv | 40 ++++
 rtl/pc_next_mux.sv | 36 +++
 rtl/pc_unit.sv | 110 +++++++++++
 tb/tb_pc_unit.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
//------------------------------------------------------------------------------
// pc_unit_pkg : state encoding and constants shared by the PC stage
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_unit_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

`default_nettype wire

// File: rtl/pc_unit_if.sv
//------------------------------------------------------------------------------
// pc_unit_if : control inputs and PC outputs of the program-counter stage
// Revision   : 1.0 - initial release (counter signals present with PC_STATS_EN)
//------------------------------------------------------------------------------
`default_nettype none

interface pc_unit_if #(
    parameter int WIDTH = 32
`ifdef PC_STATS_EN
    , parameter int CNT_WIDTH = 16
`endif
);
    logic             en;
    logic             controleMux;
    logic             jump;
    logic [WIDTH-1:0] imm_ext;
    logic [25:0]      jaddr;
    logic             halt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             pc_valid;
    logic             halted;
`ifdef PC_STATS_EN
    logic [CNT_WIDTH-1:0] br_count;
    logic [CNT_WIDTH-1:0] j_count;

    modport master (output en, controleMux, jump, imm_ext, jaddr, halt,
                    input  pc, pc_plus4, pc_valid, halted, br_count, j_count);
    modport slave  (input  en, controleMux, jump, imm_ext, jaddr, halt,
                    output pc, pc_plus4, pc_valid, halted, br_count, j_count);
`else
    modport master (output en, controleMux, jump, imm_ext, jaddr, halt,
                    input  pc, pc_plus4, pc_valid, halted);
    modport slave  (input  en, controleMux, jump, imm_ext, jaddr, halt,
                    output pc, pc_plus4, pc_valid, halted);
`endif

endinterface

`default_nettype wire

// File: rtl/pc_next_mux.sv
//------------------------------------------------------------------------------
// pc_next_mux : next-PC select (jump > branch > sequential)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_next_mux #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] pc_plus4,
    input  wire logic [WIDTH-1:0] imm_ext,
    input  wire logic [25:0]      jaddr,
    input  wire logic             jump,
    input  wire logic             branch,
    output logic      [WIDTH-1:0] next_pc
);

    logic [WIDTH-1:0] w_branch_target;
    logic [WIDTH-1:0] w_jump_target;

    // Word offset scaled to bytes; the adder wraps modulo 2^WIDTH.
    assign w_branch_target = pc_plus4 + (imm_ext << 2);
    assign w_jump_target   = {pc_plus4[WIDTH-1:WIDTH-4], jaddr, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = w_jump_target;
        end else if (branch) begin
            next_pc = w_branch_target;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
//------------------------------------------------------------------------------
// pc_unit : PC register with start/run/halt sequencing; PC_STATS_EN adds counters
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
`ifdef PC_STATS_EN
    , parameter int             CNT_WIDTH = 16
`endif
) (
    input wire logic  clk,
    input wire logic  rst_n,
    pc_unit_if.slave  bus
);

    pc_state_t        r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic             r_halted;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_advance;

    assign w_pc_plus4 = r_pc + WIDTH'(PC_INCR);
    assign w_advance  = (r_state == S_RUN) && bus.en && !bus.halt;

    pc_next_mux #(
        .WIDTH (WIDTH)
    ) u_next_mux (
        .pc_plus4 (w_pc_plus4),
        .imm_ext  (bus.imm_ext),
        .jaddr    (bus.jaddr),
        .jump     (bus.jump),
        .branch   (bus.controleMux),
        .next_pc  (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_START;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_START: begin
                    r_state    <= S_RUN;
                    r_pc_valid <= 1'b1;
                end
                S_RUN: begin
                    if (bus.en) begin
                        if (bus.halt) begin
                            r_state    <= S_HALT;
                            r_pc_valid <= 1'b0;
                            r_halted   <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state    <= S_START;
                    r_pc_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus4 = w_pc_plus4;
    assign bus.pc_valid = r_pc_valid;
    assign bus.halted   = r_halted;

`ifdef PC_STATS_EN
    logic [CNT_WIDTH-1:0] r_br_count;
    logic [CNT_WIDTH-1:0] r_j_count;

    // Counts follow the path the mux actually selects, so jump shadows branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_count <= '0;
            r_j_count  <= '0;
        end else if (w_advance) begin
            if (bus.jump) begin
                if (r_j_count != '1) r_j_count <= r_j_count + CNT_WIDTH'(1);
            end else if (bus.controleMux) begin
                if (r_br_count != '1) r_br_count <= r_br_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.br_count = r_br_count;
    assign bus.j_count  = r_j_count;
`else
    logic w_unused_advance;
    assign w_unused_advance = w_advance;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//------------------------------------------------------------------------------
// tb_pc_unit : directed self-checking bench for pc_unit
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

`ifdef PC_STATS_EN
    pc_unit_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();
    pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`else
    pc_unit_if #(.WIDTH(32)) bus ();
    pc_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic br, input logic j,
                         input logic [31:0] imm, input logic [25:0] ja, input logic h);
        bus.en          = en;
        bus.controleMux = br;
        bus.jump        = j;
        bus.imm_ext     = imm;
        bus.jaddr       = ja;
        bus.halt        = h;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        step();
        step();
        chk("reset_pc",       bus.pc,       32'h0);
        chk("reset_valid",    bus.pc_valid, 32'h0);
        chk("reset_halted",   bus.halted,   32'h0);

        rst_n = 1'b1;
        chk("start_valid",    bus.pc_valid, 32'h0);
        step();
        chk("run_valid",      bus.pc_valid, 32'h1);
        chk("run_pc0",        bus.pc,       32'h0);
        chk("run_plus4",      bus.pc_plus4, 32'h4);
        step();
        chk("seq_pc4",        bus.pc,       32'h4);
        step();
        chk("seq_pc8",        bus.pc,       32'h8);

        drive(1'b1, 1'b0, 1'b1, 32'h0, 26'h10, 1'b0);
        step();
        chk("jump_to_40",     bus.pc,       32'h40);
        drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0, 1'b0);
        step();
        chk("branch_back",    bus.pc,       32'h3C);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 26'h10, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h3, 26'h0, 1'b0);
        step();
        chk("branch_fwd",     bus.pc,       32'h50);

        // 0x54 + 0x0FFFFFAC reaches 0x1000_0000
        drive(1'b1, 1'b1, 1'b0, 32'h03FF_FFEB, 26'h0, 1'b0);
        step();
        chk("branch_far",     bus.pc,       32'h1000_0000);
        drive(1'b1, 1'b1, 1'b1, 32'h3, 26'h10, 1'b0);
        step();
        chk("jump_wins",      bus.pc,       32'h1000_0040);

        drive(1'b0, 1'b1, 1'b0, 32'h3, 26'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold",  bus.pc,       32'h1000_0040);
        end
        chk("stall_valid",    bus.pc_valid, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        step();
        chk("stall_resume",   bus.pc,       32'h1000_0044);

        // 0x1000_0048 + 0xEFFFFFB4 reaches 0xFFFF_FFFC
        drive(1'b1, 1'b1, 1'b0, 32'hFBFF_FFED, 26'h0, 1'b0);
        step();
        chk("to_top",         bus.pc,       32'hFFFF_FFFC);
        chk("top_plus4",      bus.pc_plus4, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        step();
        chk("wrap_zero",      bus.pc,       32'h0);
`ifdef PC_STATS_EN
        chk("br_count",       32'(bus.br_count), 32'd4);
        chk("j_count",        32'(bus.j_count),  32'd3);
`endif

        drive(1'b1, 1'b0, 1'b1, 32'h0, 26'h8, 1'b0);
        step();
        chk("jump_to_20",     bus.pc,       32'h20);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 26'h30, 1'b1);
        step();
        chk("halt_pc",        bus.pc,       32'h20);
        chk("halt_flag",      bus.halted,   32'h1);
        chk("halt_valid",     bus.pc_valid, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h5, 26'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 26'h3FF, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        step();
        chk("halt_frozen",    bus.pc,       32'h20);
        chk("halt_sticky",    bus.halted,   32'h1);
        chk("halt_plus4",     bus.pc_plus4, 32'h24);

        rst_n = 1'b0;
        step();
        chk("rereset_pc",     bus.pc,       32'h0);
        chk("rereset_halted", bus.halted,   32'h0);
`ifdef PC_STATS_EN
        chk("rereset_br",     32'(bus.br_count), 32'd0);
`endif
        // en=0 and halt=1 must not block the start cycle
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 1'b1);
        step();
        chk("start_ign_valid", bus.pc_valid, 32'h1);
        chk("start_ign_halt",  bus.halted,   32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 26'h0, 1'b0);
        step();
        chk("restart_seq",    bus.pc,       32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
